// File: rtl/chacha20_poly1305_ctrl.sv
// Sequencer for one ChaCha20-Poly1305 AEAD operation: one-time key, AAD, message
// blocks and the length block, steering the chacha_core and poly1305 handshakes.
module chacha20_poly1305_ctrl (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         start,
  input  logic         encdec,
  input  logic [31:0]  aad_len,
  input  logic [31:0]  msg_len,
  output logic         busy,
  input  logic         aad_valid,
  output logic         aad_ready,
  input  logic [127:0] aad_data,
  input  logic         msg_valid,
  output logic         msg_ready,
  input  logic [511:0] msg_data,
  output logic         out_valid,
  output logic [511:0] out_data,
  output logic         done,
  output logic         cc_init,
  output logic [31:0]  cc_ctr,
  output logic [511:0] cc_data_in,
  input  logic         cc_ready,
  input  logic         cc_data_valid,
  input  logic [511:0] cc_data_out,
  output logic         p_init,
  output logic [255:0] p_key,
  output logic         p_next,
  output logic [127:0] p_block,
  output logic         p_finish,
  input  logic         p_ready
);

  typedef enum logic [3:0] {
    S_IDLE, S_KEYGEN, S_KWAIT, S_PKEY, S_AAD, S_MSG_REQ, S_MSG_CC,
    S_MSG_WAIT, S_MSG_OUT, S_MSG_POLY, S_LEN, S_FIN, S_DONE
  } state_t;

  state_t        state_reg, state_next;
  logic          encdec_reg;
  logic [31:0]   aad_len_reg, msg_len_reg;
  logic [31:0]   aad_rem_reg, msg_rem_reg;
  logic [31:0]   ctr_reg;
  logic [511:0]  msg_reg, res_reg;
  logic [255:0]  key_reg;
  logic [1:0]    chunk_reg;
  logic          cc_w0_reg, p_w0_reg, fin_sent_reg;

  logic          cc_ok, cc_done, p_ok;
  logic [4:0]    aad_take;
  logic [6:0]    msg_take;
  logic [1:0]    last_idx;
  logic          last_chunk;
  logic [511:0]  msg_mask, cc_masked, msg_masked, poly_src;
  logic [127:0]  aad_mask, aad_masked, chunk_data, len_block;

  // The ready input is ignored the cycle after each pulse (engine still latching it).
  assign cc_ok   = cc_ready && !cc_w0_reg;
  assign cc_done = cc_ok && cc_data_valid;
  assign p_ok    = p_ready && !p_w0_reg;

  assign aad_take   = (aad_rem_reg > 32'd16) ? 5'd16 : aad_rem_reg[4:0];
  assign msg_take   = (msg_rem_reg > 32'd64) ? 7'd64 : msg_rem_reg[6:0];
  assign last_idx   = 2'((msg_take - 7'd1) >> 4);
  assign last_chunk = (chunk_reg == last_idx);

  for (genvar gi = 0; gi < 64; gi++) begin : g_msg_mask
    localparam logic [6:0] BYTE_IDX = 7'(gi);
    assign msg_mask[8*gi +: 8] = (BYTE_IDX < msg_take) ? 8'hff : 8'h00;
  end

  for (genvar gi = 0; gi < 16; gi++) begin : g_aad_mask
    localparam logic [4:0] BYTE_IDX = 5'(gi);
    assign aad_mask[8*gi +: 8] = (BYTE_IDX < aad_take) ? 8'hff : 8'h00;
  end

  assign cc_masked  = cc_data_out & msg_mask;
  assign msg_masked = msg_reg & msg_mask;
  assign aad_masked = aad_data & aad_mask;
  // Poly1305 always authenticates ciphertext: our result when encrypting, the input when decrypting.
  assign poly_src   = encdec_reg ? res_reg : msg_masked;
  assign chunk_data = poly_src[{chunk_reg, 7'd0} +: 128];
  assign len_block  = {32'd0, msg_len_reg, 32'd0, aad_len_reg};

  assign busy       = (state_reg != S_IDLE);
  assign p_key      = key_reg;
  assign cc_data_in = msg_reg;
  assign out_data   = res_reg;

  always_ff @(posedge clk) begin
    if (!reset_n) state_reg <= S_IDLE;
    else          state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    aad_ready  = 1'b0;
    msg_ready  = 1'b0;
    out_valid  = 1'b0;
    done       = 1'b0;
    cc_init    = 1'b0;
    cc_ctr     = 32'd0;
    p_init     = 1'b0;
    p_next     = 1'b0;
    p_block    = 128'd0;
    p_finish   = 1'b0;
    case (state_reg)
      S_IDLE: begin
        if (start) state_next = S_KEYGEN;
      end
      S_KEYGEN: begin
        if (cc_ok) begin
          cc_init    = 1'b1;
          state_next = S_KWAIT;
        end
      end
      S_KWAIT: begin
        if (cc_done) state_next = S_PKEY;
      end
      S_PKEY: begin
        if (p_ok) begin
          p_init     = 1'b1;
          state_next = S_AAD;
        end
      end
      S_AAD: begin
        if (aad_rem_reg == 32'd0) begin
          state_next = S_MSG_REQ;
        end else begin
          aad_ready = p_ok;
          if (p_ok && aad_valid) begin
            p_next  = 1'b1;
            p_block = aad_masked;
          end
        end
      end
      S_MSG_REQ: begin
        if (msg_rem_reg == 32'd0) begin
          state_next = S_LEN;
        end else begin
          msg_ready = 1'b1;
          if (msg_valid) state_next = S_MSG_CC;
        end
      end
      S_MSG_CC: begin
        if (cc_ok) begin
          cc_init    = 1'b1;
          cc_ctr     = ctr_reg;
          state_next = S_MSG_WAIT;
        end
      end
      S_MSG_WAIT: begin
        if (cc_done) state_next = S_MSG_OUT;
      end
      S_MSG_OUT: begin
        out_valid  = 1'b1;
        state_next = S_MSG_POLY;
      end
      S_MSG_POLY: begin
        if (p_ok) begin
          p_next  = 1'b1;
          p_block = chunk_data;
          if (last_chunk) state_next = S_MSG_REQ;
        end
      end
      S_LEN: begin
        if (p_ok) begin
          p_next     = 1'b1;
          p_block    = len_block;
          state_next = S_FIN;
        end
      end
      S_FIN: begin
        if (!fin_sent_reg) begin
          if (p_ok) p_finish = 1'b1;
        end else if (p_ok) begin
          state_next = S_DONE;
        end
      end
      S_DONE: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      encdec_reg   <= 1'b0;
      aad_len_reg  <= 32'd0;
      msg_len_reg  <= 32'd0;
      aad_rem_reg  <= 32'd0;
      msg_rem_reg  <= 32'd0;
      ctr_reg      <= 32'd0;
      msg_reg      <= 512'd0;
      res_reg      <= 512'd0;
      key_reg      <= 256'd0;
      chunk_reg    <= 2'd0;
      cc_w0_reg    <= 1'b0;
      p_w0_reg     <= 1'b0;
      fin_sent_reg <= 1'b0;
    end else begin
      cc_w0_reg <= cc_init;
      p_w0_reg  <= p_init | p_next | p_finish;
      if (state_reg == S_IDLE && start) begin
        encdec_reg   <= encdec;
        aad_len_reg  <= aad_len;
        msg_len_reg  <= msg_len;
        aad_rem_reg  <= aad_len;
        msg_rem_reg  <= msg_len;
        ctr_reg      <= 32'd1;
        msg_reg      <= 512'd0;
        chunk_reg    <= 2'd0;
        fin_sent_reg <= 1'b0;
      end
      if (state_reg == S_KWAIT && cc_done) key_reg <= cc_data_out[255:0];
      if (state_reg == S_AAD && p_next) aad_rem_reg <= aad_rem_reg - {27'd0, aad_take};
      if (msg_ready && msg_valid) msg_reg <= msg_data;
      if (state_reg == S_MSG_WAIT && cc_done) res_reg <= cc_masked;
      if (state_reg == S_MSG_POLY && p_next) begin
        if (last_chunk) begin
          chunk_reg   <= 2'd0;
          msg_rem_reg <= msg_rem_reg - {25'd0, msg_take};
          ctr_reg     <= ctr_reg + 32'd1;
        end else begin
          chunk_reg <= chunk_reg + 2'd1;
        end
      end
      if (p_finish) fin_sent_reg <= 1'b1;
    end
  end

endmodule

// File: tb/tb_chacha20_poly1305_ctrl.sv
// Randomized bench for chacha20_poly1305_ctrl: behavioural engine stubs plus a
// byte-level reference of the expected block, keystream and Poly1305 call sequence.
module tb_chacha20_poly1305_ctrl;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         reset_n, start, encdec, busy;
  logic [31:0]  aad_len, msg_len;
  logic         aad_valid, aad_ready, msg_valid, msg_ready, out_valid, done;
  logic [127:0] aad_data, p_block;
  logic [511:0] msg_data, out_data, cc_data_in, cc_data_out;
  logic         cc_init, cc_ready, cc_data_valid, p_init, p_next, p_finish, p_ready;
  logic [31:0]  cc_ctr;
  logic [255:0] p_key;

  chacha20_poly1305_ctrl dut (
    .clk(clk), .reset_n(reset_n), .start(start), .encdec(encdec),
    .aad_len(aad_len), .msg_len(msg_len), .busy(busy),
    .aad_valid(aad_valid), .aad_ready(aad_ready), .aad_data(aad_data),
    .msg_valid(msg_valid), .msg_ready(msg_ready), .msg_data(msg_data),
    .out_valid(out_valid), .out_data(out_data), .done(done),
    .cc_init(cc_init), .cc_ctr(cc_ctr), .cc_data_in(cc_data_in),
    .cc_ready(cc_ready), .cc_data_valid(cc_data_valid), .cc_data_out(cc_data_out),
    .p_init(p_init), .p_key(p_key), .p_next(p_next), .p_block(p_block),
    .p_finish(p_finish), .p_ready(p_ready)
  );

  int total = 0, bad = 0, op_id = 0, viol = 0, got_done = 0, aad_rdy_cyc = 0, msg_rdy_cyc = 0;
  bit stall_en = 0, toggle_en = 0;
  logic [7:0]   aad_mem [0:63];
  logic [7:0]   msg_mem [0:255];
  logic [31:0]  got_ctr[$];
  logic [511:0] got_out[$];
  logic [257:0] got_poly[$];

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [511:0] ks(input logic [31:0] c);
    logic [511:0] r;
    for (int j = 0; j < 64; j++) r[8*j +: 8] = 8'((c * 37) + (j * 11) + 90 + (c >> 8));
    return r;
  endfunction

  // Chacha stub: pulses sampled mid-cycle, responses applied just after the clock edge.
  initial begin
    int busy_cnt, stall_cnt;
    logic [511:0] pend;
    busy_cnt = 0; stall_cnt = 0; pend = '0;
    cc_ready = 1'b1; cc_data_valid = 1'b0; cc_data_out = '0;
    forever begin
      @(negedge clk);
      if (cc_init) begin
        if (!cc_ready) viol++;
        got_ctr.push_back(cc_ctr);
        pend = ks(cc_ctr) ^ cc_data_in;
        busy_cnt = $urandom_range(1, 5);
      end
      @(posedge clk); #1;
      if (busy_cnt > 0) begin
        cc_ready = 1'b0; cc_data_valid = 1'b0; busy_cnt--;
        if (busy_cnt == 0) begin cc_ready = 1'b1; cc_data_valid = 1'b1; cc_data_out = pend; end
      end else if (stall_cnt > 0) begin
        stall_cnt--; cc_ready = (stall_cnt == 0);
      end else if (stall_en && $urandom_range(0, 29) == 0) begin
        stall_cnt = 20; cc_ready = 1'b0;
      end
    end
  end

  initial begin
    int busy_cnt, stall_cnt;
    busy_cnt = 0; stall_cnt = 0;
    p_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (p_init || p_next || p_finish) begin
        if (!p_ready || (32'(p_init) + 32'(p_next) + 32'(p_finish)) > 1) viol++;
        if (p_init)      got_poly.push_back({2'd1, p_key});
        else if (p_next) got_poly.push_back({2'd2, 128'd0, p_block});
        else             got_poly.push_back({2'd3, 256'd0});
        busy_cnt = $urandom_range(1, 4);
      end
      @(posedge clk); #1;
      if (busy_cnt > 0) begin
        p_ready = 1'b0; busy_cnt--;
        if (busy_cnt == 0) p_ready = 1'b1;
      end else if (stall_cnt > 0) begin
        stall_cnt--; p_ready = (stall_cnt == 0);
      end else if (stall_en && $urandom_range(0, 29) == 0) begin
        stall_cnt = 20; p_ready = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (out_valid) got_out.push_back(out_data);
      if (done) got_done++;
      if (aad_ready) aad_rdy_cyc++;
      if (msg_ready) msg_rdy_cyc++;
    end
  end

  task automatic drive_aad(input int len);
    logic [127:0] d;
    bit hs;
    int g;
    for (int w = 0; w < (len + 15) / 16; w++) begin
      for (int j = 0; j < 16; j++) d[8*j +: 8] = (w * 16 + j < len) ? aad_mem[w * 16 + j] : 8'($urandom);
      aad_data = d; hs = 0; g = 0;
      while (!hs && g < 5000) begin
        aad_valid = toggle_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge clk); hs = aad_valid && aad_ready;
        @(posedge clk); #1; g++;
      end
      chk($sformatf("op%0d_aad_hs%0d", op_id, w), 512'(hs), 512'd1);
    end
    aad_valid = 1'b0;
  endtask

  task automatic drive_msg(input int len);
    logic [511:0] d;
    bit hs;
    int g;
    for (int b = 0; b < (len + 63) / 64; b++) begin
      for (int j = 0; j < 64; j++) d[8*j +: 8] = (b * 64 + j < len) ? msg_mem[b * 64 + j] : 8'($urandom);
      msg_data = d; hs = 0; g = 0;
      while (!hs && g < 5000) begin
        msg_valid = toggle_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        @(negedge clk); hs = msg_valid && msg_ready;
        @(posedge clk); #1; g++;
      end
      chk($sformatf("op%0d_msg_hs%0d", op_id, b), 512'(hs), 512'd1);
    end
    msg_valid = 1'b0;
  endtask

  // Random start pulses while busy (including the DONE cycle) must be ignored.
  task automatic wait_done();
    int g;
    g = 0;
    while (got_done == 0 && g < 20000) begin
      start = toggle_en ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk); #1; g++;
    end
    start = 1'b0;
    chk($sformatf("op%0d_done_seen", op_id), 512'(got_done), 512'd1);
  endtask

  task automatic check_idle(input string tag);
    chk({tag, "_ctl"}, 512'({busy, aad_ready, msg_ready, out_valid, done, cc_init, cc_ctr,
                              p_init, p_next, p_finish}), 512'd0);
    chk({tag, "_out_data"}, out_data, 512'd0);
    chk({tag, "_cc_data_in"}, cc_data_in, 512'd0);
    chk({tag, "_p_key_block"}, 512'({p_key, p_block}), 512'd0);
  endtask

  task automatic run_op(input int al, input int ml, input bit enc);
    logic [511:0] exp_out[$];
    logic [257:0] exp_poly[$];
    logic [511:0] k, ob, mb, src;
    logic [127:0] blk;
    int nblk, take;
    op_id++;
    for (int i = 0; i < 64; i++)  aad_mem[i] = 8'($urandom);
    for (int i = 0; i < 256; i++) msg_mem[i] = 8'($urandom);
    got_ctr.delete(); got_out.delete(); got_poly.delete();
    got_done = 0; viol = 0; aad_rdy_cyc = 0; msg_rdy_cyc = 0;
    encdec = enc; aad_len = al; msg_len = ml; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    fork
      drive_aad(al);
      drive_msg(ml);
      wait_done();
    join
    @(negedge clk);
    chk($sformatf("op%0d_busy_after_done", op_id), 512'(busy), 512'd0);
    @(posedge clk); #1;

    nblk = (ml + 63) / 64;
    k = ks(0);
    exp_poly.push_back({2'd1, k[255:0]});
    for (int w = 0; w < (al + 15) / 16; w++) begin
      for (int j = 0; j < 16; j++) blk[8*j +: 8] = (w * 16 + j < al) ? aad_mem[w * 16 + j] : 8'd0;
      exp_poly.push_back({2'd2, 128'd0, blk});
    end
    for (int b = 0; b < nblk; b++) begin
      take = (ml - 64 * b > 64) ? 64 : ml - 64 * b;
      k = ks(32'(b + 1));
      for (int j = 0; j < 64; j++) begin
        mb[8*j +: 8] = (j < take) ? msg_mem[64 * b + j] : 8'd0;
        ob[8*j +: 8] = (j < take) ? (msg_mem[64 * b + j] ^ k[8*j +: 8]) : 8'd0;
      end
      exp_out.push_back(ob);
      src = enc ? ob : mb;
      for (int c = 0; c < (take + 15) / 16; c++) exp_poly.push_back({2'd2, 128'd0, src[128*c +: 128]});
    end
    exp_poly.push_back({2'd2, 128'd0, 32'd0, 32'(ml), 32'd0, 32'(al)});
    exp_poly.push_back({2'd3, 256'd0});

    chk($sformatf("op%0d_n_cc", op_id), 512'(got_ctr.size()), 512'(nblk + 1));
    for (int i = 0; i < got_ctr.size() && i <= nblk; i++)
      chk($sformatf("op%0d_cc_ctr%0d", op_id, i), 512'(got_ctr[i]), 512'(i));
    chk($sformatf("op%0d_n_out", op_id), 512'(got_out.size()), 512'(exp_out.size()));
    for (int i = 0; i < got_out.size() && i < exp_out.size(); i++)
      chk($sformatf("op%0d_out%0d", op_id, i), got_out[i], exp_out[i]);
    chk($sformatf("op%0d_n_poly", op_id), 512'(got_poly.size()), 512'(exp_poly.size()));
    for (int i = 0; i < got_poly.size() && i < exp_poly.size(); i++)
      chk($sformatf("op%0d_poly%0d", op_id, i), 512'(got_poly[i]), 512'(exp_poly[i]));
    chk($sformatf("op%0d_viol", op_id), 512'(viol), 512'd0);
    if (al == 0) chk($sformatf("op%0d_no_aad_ready", op_id), 512'(aad_rdy_cyc), 512'd0);
    if (ml == 0) chk($sformatf("op%0d_no_msg_ready", op_id), 512'(msg_rdy_cyc), 512'd0);
  endtask

  initial begin
    int g;
    logic [511:0] d;
    reset_n = 1'b0; start = 1'b0; encdec = 1'b0; aad_len = '0; msg_len = '0;
    aad_valid = 1'b0; aad_data = '0; msg_valid = 1'b0; msg_data = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle("reset");
    @(posedge clk); #1;
    reset_n = 1'b1;

    run_op(12, 114, 1'b1);
    run_op(12, 114, 1'b0);
    run_op(0, 0, 1'b1);
    run_op(0, 65, 1'b1);
    run_op(16, 64, 1'b0);
    stall_en = 1; toggle_en = 1;
    run_op(12, 114, 1'b1);
    for (int i = 0; i < 4; i++)
      run_op($urandom_range(0, 40), $urandom_range(1, 200), 1'($urandom_range(0, 1)));

    // Abort in MSG_WAIT: the first cycle after the counter-1 cc_init pulse.
    for (int j = 0; j < 16; j++) d[32*j +: 32] = $urandom;
    got_ctr.delete(); got_done = 0;
    encdec = 1'b1; aad_len = 0; msg_len = 64; msg_data = d; msg_valid = 1'b1; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    g = 0;
    while (got_ctr.size() < 2 && g < 2000) begin @(posedge clk); #1; g++; end
    chk("mid_rst_reached_wait", 512'(got_ctr.size()), 512'd2);
    msg_valid = 1'b0; reset_n = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    check_idle("mid_rst");
    chk("mid_rst_no_done", 512'(got_done), 512'd0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    run_op(5, 70, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/chacha20_poly1305_ctrl.md
# chacha20_poly1305_ctrl

Sequencing controller for the ChaCha20-Poly1305 AEAD datapath. One operation runs the following steps in order: generate the one-time Poly1305 key (ChaCha block, counter 0), absorb the AAD, encrypt or decrypt the message blocks (counter 1, 2, …) while feeding ciphertext to Poly1305, then absorb the length block and finish the tag. It sits between the host-side streaming interface and the chacha_core and poly1305 engine instances, and owns all block counting, padding and handshakes.

## Interface
Parameters: none.

- clk  in  1  clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  begin operation; accepted only in IDLE
- encdec  in  1  1 = encrypt, 0 = decrypt; sampled at start
- aad_len  in  32  AAD length in bytes; sampled at start
- msg_len  in  32  message length in bytes; sampled at start
- busy  out  1  high from start acceptance until done
- aad_valid / aad_ready  in / out  1  AAD word handshake
- aad_data  in  128  16 AAD bytes; byte i at [8i+7:8i]
- msg_valid / msg_ready  in / out  1  message block handshake
- msg_data  in  512  64 message bytes; same byte order
- out_valid  out  1  one-cycle pulse, out_data valid
- out_data  out  512  result block; bytes beyond msg_len zeroed
- done  out  1  one-cycle pulse; tag available at poly1305
- cc_init  out  1  one-cycle start pulse to chacha_core
- cc_ctr  out  32  block counter for the current cc_init
- cc_data_in  out  512  msg_data register; zero during keygen
- cc_ready / cc_data_valid  in  1  core status
- cc_data_out  in  512  core result
- p_init  out  1  one-cycle pulse; load p_key
- p_key  out  256  cc_data_out[255:0] of the counter-0 block, registered
- p_next  out  1  one-cycle pulse; absorb p_block as a full 16-byte block
- p_block  out  128  padded block
- p_finish  out  1  one-cycle pulse; finalize tag
- p_ready  in  1  poly1305 idle

## Operation
States and transitions:
- IDLE → KEYGEN on start.
- KEYGEN → KWAIT.
- KWAIT → PKEY.
- PKEY → AAD.
- AAD → MSG_REQ.
- MSG_REQ → MSG_CC → MSG_WAIT → MSG_OUT → MSG_POLY → MSG_REQ (repeats per message block).
- MSG_REQ → LEN → FIN → DONE → IDLE once no message bytes remain.

Step behaviour:
- KEYGEN: when cc_ready = 1, pulse cc_init with cc_ctr = 0.
- PKEY: pulse p_init with p_key when p_ready = 1.
- AAD: one aad handshake per 16 bytes, for ceil(aad_len/16) words. Bytes at or beyond the remaining count are zeroed. Each word issues p_next. aad_ready is high only when p_ready = 1 and no poly wait is pending.
- Message blocks: ctr starts at 1 and increments after each block.
- MSG_REQ: msg_ready is high and the handshake registers msg_data.
- MSG_CC: issue cc_init with cc_ctr = ctr.
- MSG_OUT: capture cc_data_out, mask it, and pulse out_valid.
- MSG_POLY: issue ceil(min(rem, 64)/16) p_next chunks in byte order. The source is the masked result when encdec = 1, or the masked msg_data when encdec = 0.
- Then rem -= min(rem, 64).
- LEN: p_block = {msg_len zero-extended to 64, aad_len zero-extended to 64}; aad_len occupies bytes 0–7.
- FIN: pulse p_finish, then wait for p_ready.
- DONE: pulse done.
- Zero-length AAD skips AAD. Zero-length message skips the message loop.
- Length counters are 32-bit. ctr cannot overflow because the maximum block count is 2^26.

## Timing
- Reset: every output is 0, state is IDLE, and all counters are cleared.
- Reset mid-operation aborts immediately with no done pulse.
- Engine handshake: a pulse is issued only when the engine's ready input = 1. The cycle after the pulse, the ready input is ignored (WAIT0). Completion is the first later cycle with ready = 1; for the chacha core, cc_data_valid = 1 is also required.
- start while busy is ignored. start in the DONE cycle is also ignored.
- busy rises the cycle after start is accepted and falls in the cycle after done.
- out_valid occurs exactly 1 cycle after the core completes.
- At most one p_next is outstanding.
- Host valid may stay high across ready = 0 with no data loss. Data is held stable until the handshake.
- Minimum overhead per message block is 4 cycles plus core latency plus 4 × (poly latency + 2).

## Test plan
- RFC 8439 §2.8.2 vector (aad_len = 12, msg_len = 114, encrypt) with real engines → out_valid 2× (cc_ctr 1, 2). p_next count = 10 (1 AAD + 8 message + 1 length). done, tag = 1ae10b594f09e26a7e902ecbd0600691.
- Same vector with decrypt, ciphertext in → plaintext out matching the RFC, identical tag.
- aad_len = 0, msg_len = 0 → sequence KEYGEN, then a single p_next {64'h0, 64'h0}, p_finish, done. No aad_ready or msg_ready ever asserted.
- msg_len = 65 → 2 blocks. The second out_data has only byte 0 nonzero, and the second block issues exactly 1 p_next.
- Stalled engines (cc_ready and p_ready held low for 20 cycles at random points) and host valid toggling → identical outputs and tag. No pulse while the engine is not ready.
- reset_n low during MSG_WAIT → all outputs 0 next cycle. A new start then completes correctly with cc_ctr restarting at 0.
